// File: rtl/shift_sequencer.sv
// shift_sequencer: shares one combinational barrel shifter between two requesters and builds SRA/ROR from two passes.
// Define SHIFT_SEQ_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (req0 wins) otherwise.
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] sh_a,
    output logic [WIDTH-1:0] sh_b,
    output logic             sh_dir,
    input  logic [WIDTH-1:0] sh_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id
);
    // state | meaning
    // IDLE  | arbitrate and accept one request
    // PASS1 | first shifter pass; final result for SLL/SRL, partial for SRA/ROR
    // PASS2 | second pass: sign fill (SRA) or wrapped-around bits (ROR)
    // DONE  | hold response until rsp_ready
    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t               state, state_nxt;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [SHAMT_W-1:0]   amt_q;
    logic                 id_q;
    logic [WIDTH-1:0]     tmp_q;
    logic [1:0]           grant;
    logic                 accept;
    logic [WIDTH-1:0]     amt_ext;
    logic                 unused_b;

    assign unused_b = ^{req0_b[WIDTH-1:SHAMT_W], req1_b[WIDTH-1:SHAMT_W]};
    assign amt_ext  = {{(WIDTH-SHAMT_W){1'b0}}, amt_q};

`ifdef SHIFT_SEQ_ROUND_ROBIN_EN
    logic last_grant;

    // last_grant=1 hands the next contended grant to req0
    always_comb begin
        grant    = 2'b00;
        grant[0] = req0_valid & (~req1_valid | last_grant);
        grant[1] = req1_valid & (~req0_valid | ~last_grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= ~last_grant;
    end
`else
    always_comb begin
        grant    = 2'b00;
        grant[0] = req0_valid;
        grant[1] = req1_valid & ~req0_valid;
    end
`endif

    assign req0_ready = rst_n & (state == IDLE) & grant[0];
    assign req1_ready = rst_n & (state == IDLE) & grant[1];
    assign accept     = req0_ready | req1_ready;
    assign rsp_valid  = (state == DONE);

    always_comb begin
        state_nxt = state;
        sh_a      = '0;
        sh_b      = '0;
        sh_dir    = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = PASS1;
            PASS1: begin
                sh_a      = a_q;
                sh_b      = amt_ext;
                sh_dir    = (op_q != OP_SLL);
                state_nxt = (op_q == OP_SLL || op_q == OP_SRL) ? DONE : PASS2;
            end
            PASS2: begin
                if (op_q == OP_SRA) begin
                    sh_a   = '1;
                    sh_b   = amt_ext;
                    sh_dir = 1'b1;
                end else begin
                    // amt=0 gives sh_b=WIDTH, the shifter returns 0 and the rotate yields a
                    sh_a   = a_q;
                    sh_b   = WIDTH'(WIDTH) - amt_ext;
                    sh_dir = 1'b0;
                end
                state_nxt = DONE;
            end
            DONE: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            amt_q    <= '0;
            id_q     <= 1'b0;
            tmp_q    <= '0;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    op_q  <= req1_ready ? req1_op : req0_op;
                    a_q   <= req1_ready ? req1_a : req0_a;
                    amt_q <= req1_ready ? req1_b[SHAMT_W-1:0] : req0_b[SHAMT_W-1:0];
                    id_q  <= req1_ready;
                end
                PASS1: begin
                    tmp_q <= sh_out;
                    if (op_q == OP_SLL || op_q == OP_SRL) begin
                        rsp_data <= sh_out;
                        rsp_id   <= id_q;
                    end
                end
                PASS2: begin
                    rsp_id <= id_q;
                    if (op_q == OP_SRA)
                        rsp_data <= tmp_q | (a_q[WIDTH-1] ? ~sh_out : '0);
                    else
                        rsp_data <= tmp_q | sh_out;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized traffic against a behavioural model.
// Expectations for contended grants follow SHIFT_SEQ_ROUND_ROBIN_EN when it is defined.
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [31:0] sh_a, sh_b, sh_out;
    logic        sh_dir;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_id;

    int vectors = 0;
    int miscompares = 0;
    logic rr_last = 1'b1;

    always #5 clk = ~clk;

    // external barrel shifter: amounts >= 32 shift everything out
    assign sh_out = sh_dir ? (sh_a >> sh_b) : (sh_a << sh_b);

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .sh_a(sh_a), .sh_b(sh_b), .sh_dir(sh_dir), .sh_out(sh_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int amt;
        logic [63:0] d;
        amt = int'(b % 32);
        d = {a, a} >> amt;
        case (op)
            2'b00:   return a << amt;
            2'b01:   return a >> amt;
            2'b10:   return $unsigned($signed(a) >>> amt);
            default: return d[31:0];
        endcase
    endfunction

    // One transaction; called at a point away from the clock edge with the DUT in IDLE.
    task automatic txn(input logic v0, input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                       input int hold);
        logic        exp_id;
        logic [31:0] exp_data;
        int          lat;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready = 1'b0;
        #1;
        if (v0 && v1) begin
`ifdef SHIFT_SEQ_ROUND_ROBIN_EN
            exp_id = ~rr_last;
`else
            exp_id = 1'b0;
`endif
        end else begin
            exp_id = v1;
        end
        check("grant", {30'd0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
        exp_data = exp_id ? ref_shift(op1, a1, b1) : ref_shift(op0, a0, b0);
        @(posedge clk);
        #1;
        rr_last = ~rr_last;
        if (exp_id) req1_valid = 1'b0; else req0_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 10);
        check("latency", 32'(lat), ((exp_id ? op1 : op0) < 2'b10) ? 32'd2 : 32'd3);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_id", {31'd0, rsp_id}, {31'd0, exp_id});
        check("ready_in_done", {30'd0, req1_ready, req0_ready}, 32'd0);
        check("sh_a_in_done", sh_a, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_data", rsp_data, exp_data);
            check("hold_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("back_to_idle", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [1:0] vsel;
        // reset state
        req0_valid = 1'b1;
        #12;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_sh_b", sh_b, 32'd0);
        check("rst_sh_dir", {31'd0, sh_dir}, 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_last = 1'b1;
        #1;

        // directed cases
        txn(1, 2'b00, 32'h0000_0001, 32'd4, 0, 2'b00, 0, 0, 0);
        txn(0, 2'b00, 0, 0, 1, 2'b10, 32'h8000_0000, 32'h24, 0);
        txn(0, 2'b00, 0, 0, 1, 2'b10, 32'h4000_0000, 32'h24, 0);
        txn(1, 2'b11, 32'h1234_5678, 32'd8, 0, 2'b00, 0, 0, 0);
        txn(1, 2'b11, 32'h1234_5678, 32'd0, 0, 2'b00, 0, 0, 0);
        txn(1, 2'b11, 32'h1234_5678, 32'd32, 0, 2'b00, 0, 0, 0);
        check("ror_b8_value", ref_shift(2'b11, 32'h1234_5678, 32'd8), 32'h7812_3456);

        // contention from a fresh reset so the first grant is req0
        rst_n = 1'b0;
        #1;
        rr_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++)
            txn(1, 2'b00, 32'h1, 32'(i), 1, 2'b01, 32'h8000_0000, 32'(i), 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // backpressure in DONE
        txn(1, 2'b01, 32'hF000_000F, 32'd3, 0, 2'b00, 0, 0, 5);

        // reset during PASS2 of a ROR
        req0_valid = 1'b1; req0_op = 2'b11; req0_a = 32'hDEAD_BEEF; req0_b = 32'd8;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pass2_ror_sh_b", sh_b, 32'd24);
        check("pass2_ror_sh_dir", {31'd0, sh_dir}, 32'd0);
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'h0000_0003; req0_b = 32'd5;
        #1;
        check("midop_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("midop_rst_ready", {31'd0, req0_ready}, 32'd0);
        rr_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        txn(1, 2'b00, 32'h0000_0003, 32'd5, 0, 2'b00, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            vsel = 2'($urandom_range(1, 3));
            txn(vsel[0], 2'($urandom), $urandom, $urandom, vsel[1], 2'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 2)));
            req0_valid = 1'b0; req1_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
